mmc1_serial_mapper: RTL and testbench

Parametrised second-generation MMC1-class mapper for the NES core. It translates CPU (PRG) and PPU (CHR) bus addresses into the 22-bit linear memory space and steers nametable accesses to internal VRAM. It has a 5-write serial load engine with consecutive-write rejection, PRG-RAM enable and bank select, and optional SxROM outer-bank support. It sits between the CPU/PPU address buses and the memory arbiter, in the same slot as the existing fixed-width mapper.

---
 rtl/mmc1_pkg.sv | 27 ++
 rtl/mmc1_serial_loader.sv | 53 +++++
 rtl/mmc1_serial_mapper.sv | 130 +++++++++++++
 tb/tb_mmc1_serial_mapper.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1-class serial mapper: register indices,
// control-field enums and the power-on control value.
package mmc1_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  localparam logic [4:0] CTRL_RST  = 5'h0C;
  localparam logic [2:0] LOAD_LAST = 3'd4;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'd0,
    MIR_ONE_HI = 2'd1,
    MIR_VERT   = 2'd2,
    MIR_HORZ   = 2'd3
  } mirror_e;

  typedef enum logic [1:0] {
    PRG_32K_A  = 2'd0,
    PRG_32K_B  = 2'd1,
    PRG_FIX_LO = 2'd2,
    PRG_FIX_HI = 2'd3
  } prg_mode_e;

endpackage

// File: rtl/mmc1_serial_loader.sv
// Five-write LSB-first serial loader with consecutive-cycle write rejection.
// Emits a one-cycle commit (index + value) or soft reset, qualified by ce.
module mmc1_serial_loader
  import mmc1_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       prg_write,
  input  logic [2:0] addr_hi,
  input  logic       din_reset,
  input  logic       din_bit,
  output logic       commit,
  output logic [1:0] commit_idx,
  output logic [4:0] commit_val,
  output logic       soft_rst
);

  logic [4:0] shift;
  logic [2:0] cnt;
  logic       last_wr;
  logic       addr_wr;
  logic       accept;

  // Any write into $8000-$FFFF arms the filter, even one that gets rejected.
  assign addr_wr = ce && prg_write && addr_hi[2];
  assign accept  = addr_wr && !last_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      cnt     <= '0;
      last_wr <= 1'b0;
    end else if (ce) begin
      last_wr <= addr_wr;
      if (accept) begin
        if (din_reset || cnt == LOAD_LAST) begin
          shift <= '0;
          cnt   <= '0;
        end else begin
          shift <= {din_bit, shift[4:1]};
          cnt   <= cnt + 3'd1;
        end
      end
    end
  end

  assign soft_rst   = accept && din_reset;
  assign commit     = accept && !din_reset && (cnt == LOAD_LAST);
  assign commit_idx = addr_hi[1:0];
  assign commit_val = {din_bit, shift[4:1]};

endmodule

// File: rtl/mmc1_serial_mapper.sv
// MMC1-class mapper: bank registers plus PRG/CHR/nametable address translation.
// Define MMC1_SXROM_EN for the SxROM outer PRG bank and PRG-RAM bank select.
module mmc1_serial_mapper
  import mmc1_pkg::*;
#(
  parameter int          PRG_BANK_W = 4,
  parameter int          CHR_BANK_W = 5,
  parameter logic [21:0] PRG_BASE   = 22'h000000,
  parameter logic [21:0] CHR_BASE   = 22'h200000,
  parameter logic [21:0] RAM_BASE   = 22'h3C0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  output logic [21:0] prg_aout,
  output logic        prg_allow,
  input  logic [13:0] chr_ain,
  output logic [21:0] chr_aout,
  output logic        chr_allow,
  output logic        vram_a10,
  output logic        vram_ce
);

  logic [4:0] control, chr0, chr1, prg;
  logic       commit, soft_rst;
  logic [1:0] commit_idx;
  logic [4:0] commit_val;

  mmc1_serial_loader u_loader (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .prg_write  (prg_write),
    .addr_hi    (prg_ain[15:13]),
    .din_reset  (prg_din[7]),
    .din_bit    (prg_din[0]),
    .commit     (commit),
    .commit_idx (commit_idx),
    .commit_val (commit_val),
    .soft_rst   (soft_rst)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control <= CTRL_RST;
      chr0    <= '0;
      chr1    <= '0;
      prg     <= '0;
    end else if (ce) begin
      if (soft_rst) begin
        control <= control | CTRL_RST;
      end else if (commit) begin
        case (commit_idx)
          REG_CTRL: control <= commit_val;
          REG_CHR0: chr0    <= commit_val;
          REG_CHR1: chr1    <= commit_val;
          REG_PRG:  prg     <= commit_val;
          default:  ;
        endcase
      end
    end
  end

  logic                  outer;
  logic [1:0]            ram_bank;
  logic [PRG_BANK_W-1:0] prg_bank;
  logic [CHR_BANK_W-1:0] chr_bank;
  logic                  in_ram;
  logic                  ram_en;

  // The outer bit follows the CHR bank active for the current PPU fetch.
`ifdef MMC1_SXROM_EN
  assign outer    = (control[4] && chr_ain[12]) ? chr1[4] : chr0[4];
  assign ram_bank = chr0[3:2];
`else
  assign outer    = 1'b0;
  assign ram_bank = 2'b00;
`endif

  always_comb begin
    prg_bank = prg[PRG_BANK_W-1:0];
    case (prg_mode_e'(control[3:2]))
      PRG_32K_A, PRG_32K_B: prg_bank = {prg[PRG_BANK_W-1:1], prg_ain[14]};
      PRG_FIX_LO:           prg_bank = prg_ain[14] ? prg[PRG_BANK_W-1:0] : '0;
      PRG_FIX_HI:           prg_bank = prg_ain[14] ? '1 : prg[PRG_BANK_W-1:0];
      default:              ;
    endcase
  end

  assign in_ram = (prg_ain[15:13] == 3'b011);
  assign ram_en = !prg[4] || flags[16];

  always_comb begin
    if (in_ram) begin
      prg_aout  = RAM_BASE + 22'({ram_bank, prg_ain[12:0]});
      prg_allow = ram_en;
    end else begin
      prg_aout  = PRG_BASE + 22'({outer, prg_bank, prg_ain[13:0]});
      prg_allow = prg_ain[15] && !prg_write;
    end
  end

  always_comb begin
    if (control[4]) chr_bank = chr_ain[12] ? chr1[CHR_BANK_W-1:0] : chr0[CHR_BANK_W-1:0];
    else            chr_bank = {chr0[CHR_BANK_W-1:1], chr_ain[12]};
  end

  assign chr_aout  = CHR_BASE + 22'({chr_bank, chr_ain[11:0]});
  assign chr_allow = flags[15];
  assign vram_ce   = chr_ain[13];

  always_comb begin
    case (mirror_e'(control[1:0]))
      MIR_ONE_LO: vram_a10 = 1'b0;
      MIR_ONE_HI: vram_a10 = 1'b1;
      MIR_VERT:   vram_a10 = chr_ain[10];
      MIR_HORZ:   vram_a10 = chr_ain[11];
      default:    vram_a10 = 1'b0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{flags[31:17], flags[14:0], prg_din[6:1], prg_read, prg, chr0, chr1};

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// Self-checking bench for mmc1_serial_mapper: directed steps then random traffic
// compared against a behavioural model of the register file and address maps.
module tb_mmc1_serial_mapper;

  localparam int PW       = 4;
  localparam int CW       = 5;
  localparam int PRG_BASE = 'h000000;
  localparam int CHR_BASE = 'h200000;
  localparam int RAM_BASE = 'h3C0000;
`ifdef MMC1_SXROM_EN
  localparam bit SX = 1'b1;
`else
  localparam bit SX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] flags = '0;
  logic [15:0] prg_ain = '0;
  logic        prg_read = 1'b0;
  logic        prg_write = 1'b0;
  logic [7:0]  prg_din = '0;
  logic [21:0] prg_aout;
  logic        prg_allow;
  logic [13:0] chr_ain = '0;
  logic [21:0] chr_aout;
  logic        chr_allow;
  logic        vram_a10;
  logic        vram_ce;

  mmc1_serial_mapper #(
    .PRG_BANK_W (PW),
    .CHR_BANK_W (CW),
    .PRG_BASE   (22'(PRG_BASE)),
    .CHR_BASE   (22'(CHR_BASE)),
    .RAM_BASE   (22'(RAM_BASE))
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .flags     (flags),
    .prg_ain   (prg_ain),
    .prg_read  (prg_read),
    .prg_write (prg_write),
    .prg_din   (prg_din),
    .prg_aout  (prg_aout),
    .prg_allow (prg_allow),
    .chr_ain   (chr_ain),
    .chr_aout  (chr_aout),
    .chr_allow (chr_allow),
    .vram_a10  (vram_a10),
    .vram_ce   (vram_ce)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: accepted serial bits kept as a queue, registers as plain integers.
  bit m_bits[$];
  bit m_last;
  int m_ctrl, m_chr0, m_chr1, m_prg;

  task automatic model_reset();
    m_bits.delete();
    m_last = 1'b0;
    m_ctrl = 'h0C;
    m_chr0 = 0;
    m_chr1 = 0;
    m_prg  = 0;
  endtask

  task automatic model_step(input logic c, input logic w, input logic [15:0] a, input logic [7:0] d);
    int val;
    if (!c) return;
    if (w && a[15]) begin
      if (!m_last) begin
        if (d[7]) begin
          m_bits.delete();
          m_ctrl = m_ctrl | 'h0C;
        end else begin
          m_bits.push_back(d[0]);
          if (m_bits.size() == 5) begin
            val = 0;
            foreach (m_bits[i]) val = val | (int'(m_bits[i]) << i);
            case (a[14:13])
              2'd0:    m_ctrl = val;
              2'd1:    m_chr0 = val;
              2'd2:    m_chr1 = val;
              default: m_prg  = val;
            endcase
            m_bits.delete();
          end
        end
      end
      m_last = 1'b1;
    end else begin
      m_last = 1'b0;
    end
  endtask

  function automatic int exp_prg_aout(input logic [15:0] pa, input logic [13:0] ca);
    int a, c, nb, p, half, bank, outer, rb;
    a  = int'(pa);
    c  = int'(ca);
    nb = 1 << PW;
    if (pa[15:13] == 3'b011) begin
      rb = SX ? ((m_chr0 >> 2) & 3) : 0;
      return (RAM_BASE + rb * 8192 + (a % 8192)) % (1 << 22);
    end
    p    = m_prg % nb;
    half = (a >> 14) & 1;
    case ((m_ctrl >> 2) & 3)
      0, 1:    bank = (p - (p % 2)) + half;
      2:       bank = half ? p : 0;
      default: bank = half ? nb - 1 : p;
    endcase
    if (!SX)                                        outer = 0;
    else if (((m_ctrl >> 4) & 1) && ((c >> 12) & 1)) outer = (m_chr1 >> 4) & 1;
    else                                            outer = (m_chr0 >> 4) & 1;
    return (PRG_BASE + (outer * nb + bank) * 16384 + (a % 16384)) % (1 << 22);
  endfunction

  function automatic int exp_chr_aout(input logic [13:0] ca);
    int c, nb, a12, bank;
    c   = int'(ca);
    nb  = 1 << CW;
    a12 = (c >> 12) & 1;
    if (((m_ctrl >> 4) & 1) == 0) bank = ((m_chr0 % nb) - (m_chr0 % 2)) + a12;
    else                          bank = a12 ? (m_chr1 % nb) : (m_chr0 % nb);
    return (CHR_BASE + bank * 4096 + (c % 4096)) % (1 << 22);
  endfunction

  function automatic int exp_a10(input logic [13:0] ca);
    case (m_ctrl & 3)
      0:       return 0;
      1:       return 1;
      2:       return (int'(ca) >> 10) & 1;
      default: return (int'(ca) >> 11) & 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [15:0] a, input logic [7:0] d);
    ce        = c;
    prg_write = w;
    prg_read  = !w;
    prg_ain   = a;
    prg_din   = d;
    @(posedge clk);
    model_step(c, w, a, d);
    #1;
    ce        = 1'b0;
    prg_write = 1'b0;
  endtask

  task automatic writeGap(input logic [15:0] a, input logic b);
    applyStimulus(1'b1, 1'b1, a, {7'd0, b});
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic serialWrite(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) writeGap(a, v[i]);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] pa, input logic [13:0] ca, input logic w);
    logic exp_allow;
    prg_ain   = pa;
    chr_ain   = ca;
    prg_write = w;
    prg_read  = !w;
    ce        = 1'b0;
    @(negedge clk);
    if (pa[15:13] == 3'b011) exp_allow = !((m_prg >> 4) & 1) || flags[16];
    else                     exp_allow = pa[15] && !w;
    if (pa[15] || pa[15:13] == 3'b011) check({tag, "_prg_aout"}, 32'(prg_aout), 32'(exp_prg_aout(pa, ca)));
    check({tag, "_prg_allow"}, 32'(prg_allow), 32'(exp_allow));
    check({tag, "_chr_aout"},  32'(chr_aout),  32'(exp_chr_aout(ca)));
    check({tag, "_chr_allow"}, 32'(chr_allow), 32'(flags[15]));
    check({tag, "_vram_a10"},  32'(vram_a10),  32'(exp_a10(ca)));
    check({tag, "_vram_ce"},   32'(vram_ce),   32'(ca[13]));
    prg_write = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, pa;
    logic [7:0]  rd;
    logic        rc, rw;

    model_reset();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    $display("[TB] reset released");

    checkOutput("reset", 16'hC000, 14'h0400, 1'b0);
    check("reset_c000_last_bank", 32'(prg_aout), 32'h0003C000);
    check("reset_a10_zero", 32'(vram_a10), 32'd0);

    serialWrite(16'hE000, 5'h02);
    checkOutput("prg2", 16'h8000, 14'h0000, 1'b0);
    check("prg2_8000_bank2", 32'(prg_aout), 32'h00008000);

    // Burst of back-to-back writes: only the first lands, the rest keep the filter armed.
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b1, 1'b1, 16'h8000, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'h8000, 8'h01);
    checkOutput("burst", 16'hC000, 14'h0C00, 1'b0);
    check("burst_no_commit", 32'(prg_aout), 32'h0003C000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    writeGap(16'h8000, 1'b1);
    writeGap(16'h8000, 1'b0);
    writeGap(16'h8000, 1'b0);
    writeGap(16'h8000, 1'b1);
    checkOutput("ctrl12", 16'hC000, 14'h1400, 1'b0);
    check("ctrl12_32k_mode", 32'(prg_aout), 32'h0000C000);

    writeGap(16'h8000, 1'b1);
    writeGap(16'h8000, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h8000, 8'h80);
    applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00);
    checkOutput("softrst", 16'hC000, 14'h0800, 1'b0);
    check("softrst_fix_hi", 32'(prg_aout), 32'h0003C000);
    serialWrite(16'hE000, 5'h10);
    checkOutput("prg10", 16'h8000, 14'h1000, 1'b0);

    flags = 32'h0000_0000;
    checkOutput("ram_dis", 16'h6000, 14'h0000, 1'b0);
    check("ram_dis_allow", 32'(prg_allow), 32'd0);
    flags = 32'h0001_8000;
    checkOutput("ram_mmc1a", 16'h6123, 14'h2000, 1'b1);
    check("ram_mmc1a_allow", 32'(prg_allow), 32'd1);
    checkOutput("rom_write", 16'h9000, 14'h0000, 1'b1);

    serialWrite(16'hA000, 5'h10);
    checkOutput("outer", 16'hC000, 14'h0000, 1'b0);
    check("outer_c000", 32'(prg_aout), SX ? 32'h0007C000 : 32'h0003C000);

    // Asynchronous reset part-way through a load must drop the partial bits.
    writeGap(16'h8000, 1'b0);
    writeGap(16'h8000, 1'b1);
    #2 reset_n = 1'b0;
    #1 model_reset();
    checkOutput("midrst", 16'hC000, 14'h0800, 1'b0);
    reset_n = 1'b1;
    serialWrite(16'h8000, 5'h01);
    checkOutput("after_midrst", 16'hC000, 14'h0000, 1'b0);
    check("after_midrst_a10", 32'(vram_a10), 32'd1);

    for (int n = 0; n < 400; n++) begin
      rc = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1);
      ra = ($urandom_range(0, 3) != 0) ? {1'b1, 15'($urandom)} : 16'($urandom);
      rd = ($urandom_range(0, 15) == 0) ? 8'($urandom) | 8'h80 : 8'($urandom) & 8'h7F;
      applyStimulus(rc, rw, ra, rd);
      flags = {15'd0, 1'($urandom), 1'($urandom), 15'd0};
      case ($urandom_range(0, 2))
        0:       pa = {3'b011, 13'($urandom)};
        1:       pa = {1'b1, 15'($urandom)};
        default: pa = 16'($urandom);
      endcase
      checkOutput("rand", pa, 14'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
